// File: rtl/spi_rx_pkg.sv
// -----------------------------------------------------------------------------
// spi_rx_pkg
// Shared definitions for the SPI receive-buffer read side:
//   - spi_rx_rd_state_e : reader FSM states (IDLE, REQ, CAP, OUT)
//   - SPI_RX_DATAWIDTH  : byte width of the buffer / output stream
//   - SPI_RX_ADDRWIDTH  : buffer address width (depth = 2**ADDRWIDTH)
//   - SPI_RX_RD_LAT     : default read latency, buf_ren rise to buf_rdata valid
//   - SPI_RX_LAT_W      : width of the read-latency counter
// -----------------------------------------------------------------------------
package spi_rx_pkg;

    localparam int SPI_RX_DATAWIDTH = 8;
    localparam int SPI_RX_ADDRWIDTH = 11;
    localparam int SPI_RX_RD_LAT    = 3;
    localparam int SPI_RX_LAT_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAP  = 2'd2,
        OUT  = 2'd3
    } spi_rx_rd_state_e;

endpackage : spi_rx_pkg

// File: rtl/spi_rx_buf_reader.sv
// -----------------------------------------------------------------------------
// spi_rx_buf_reader
// Read-side controller for the SPI receive block-RAM buffer. Watches the
// buffer's not-empty flag, holds a read request for RD_LAT+1 cycles, captures
// the byte and offers it on a valid/ready stream, then advances the (wrapping)
// read address once the consumer takes it.
//
// Parameters:
//   DATAWIDTH  byte width                      (default 8)
//   ADDRWIDTH  buffer address width            (default 11)
//   RD_LAT     buf_ren rise to data valid      (default 3, legal 1..15)
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   en             1 = drain the buffer; 0 = finish current byte then idle
//   buf_not_empty  buffer holds unread data at buf_raddr
//   buf_ren        read request, held through REQ and CAP
//   buf_raddr      read address, changes only on an output transfer
//   buf_rdata      read data from the buffer
//   out_valid      out_data holds a byte
//   out_ready      consumer accepts the byte
//   out_data       captured byte
//   busy           FSM not in IDLE (decoded from the state register)
//   rd_count       bytes delivered, 16-bit wrapping   (SPI_RX_BUF_RD_CNT_EN)
//   cnt_clr        synchronous clear of rd_count      (SPI_RX_BUF_RD_CNT_EN)
//
// Optional feature: define SPI_RX_BUF_RD_CNT_EN to add the delivered-byte
// counter and its clear input. Without it neither port nor any counter logic
// exists.
// -----------------------------------------------------------------------------
module spi_rx_buf_reader
    import spi_rx_pkg::*;
#(
    parameter int DATAWIDTH = SPI_RX_DATAWIDTH,
    parameter int ADDRWIDTH = SPI_RX_ADDRWIDTH,
    parameter int RD_LAT    = SPI_RX_RD_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 buf_not_empty,
    output logic                 buf_ren,
    output logic [ADDRWIDTH-1:0] buf_raddr,
    input  logic [DATAWIDTH-1:0] buf_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 busy
`ifdef SPI_RX_BUF_RD_CNT_EN
    ,
    output logic [15:0]          rd_count,
    input  logic                 cnt_clr
`endif
);

    // Last value of the latency counter before leaving REQ.
    localparam logic [SPI_RX_LAT_W-1:0] LAT_LAST = SPI_RX_LAT_W'(RD_LAT - 1);

    spi_rx_rd_state_e        state_q, state_d;
    logic [SPI_RX_LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [ADDRWIDTH-1:0]    raddr_q, raddr_d;
    logic [DATAWIDTH-1:0]    data_q, data_d;
    logic                    ren_q, ren_d;
    logic                    valid_q, valid_d;
    logic                    xfer;

    assign xfer = valid_q && out_ready;

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        raddr_d   = raddr_q;
        data_d    = data_q;

        unique case (state_q)
            IDLE: begin
                if (en && buf_not_empty) begin
                    state_d   = REQ;
                    lat_cnt_d = '0;
                end
            end
            REQ: begin
                lat_cnt_d = lat_cnt_q + 1'b1;
                if (lat_cnt_q == LAT_LAST) begin
                    state_d = CAP;
                end
            end
            CAP: begin
                data_d  = buf_rdata;
                state_d = OUT;
            end
            OUT: begin
                if (xfer) begin
                    raddr_d = raddr_q + 1'b1;
                    // Chain straight into the next request; the one OUT cycle
                    // with buf_ren low re-arms the buffer's enable qualifier.
                    if (en && buf_not_empty) begin
                        state_d   = REQ;
                        lat_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered outputs are decoded from the next state so they line up
        // with the state they belong to.
        ren_d   = (state_d == REQ) || (state_d == CAP);
        valid_d = (state_d == OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
            raddr_q   <= '0;
            data_q    <= '0;
            ren_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            raddr_q   <= raddr_d;
            data_q    <= data_d;
            ren_q     <= ren_d;
            valid_q   <= valid_d;
        end
    end

    assign buf_ren   = ren_q;
    assign buf_raddr = raddr_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign busy      = (state_q != IDLE);

`ifdef SPI_RX_BUF_RD_CNT_EN
    logic [15:0] rd_count_q;

    // Clear wins over a same-cycle transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q <= '0;
        end else if (cnt_clr) begin
            rd_count_q <= '0;
        end else if (xfer) begin
            rd_count_q <= rd_count_q + 16'd1;
        end
    end

    assign rd_count = rd_count_q;
`endif

endmodule : spi_rx_buf_reader

// File: tb/tb_spi_rx_buf_reader.sv
// -----------------------------------------------------------------------------
// tb_spi_rx_buf_reader
// Directed bench for spi_rx_buf_reader with a buffer model, a transaction-age
// reference model and literal expectations for each scenario.
// -----------------------------------------------------------------------------
module tb_spi_rx_buf_reader;

    localparam int RD_LAT = 3;
    localparam int DEPTH  = 2048;

    logic        clk;
    logic        rst;
    logic        en;
    logic        buf_not_empty;
    logic        buf_ren;
    logic [10:0] buf_raddr;
    logic [7:0]  buf_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        busy;
    logic        cnt_clr;
`ifdef SPI_RX_BUF_RD_CNT_EN
    logic [15:0] rd_count;
`endif

    spi_rx_buf_reader dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .buf_not_empty (buf_not_empty),
        .buf_ren       (buf_ren),
        .buf_raddr     (buf_raddr),
        .buf_rdata     (buf_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .busy          (busy)
`ifdef SPI_RX_BUF_RD_CNT_EN
        ,
        .rd_count      (rd_count),
        .cnt_clr       (cnt_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit check_en    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- buffer model ----------------
    logic [7:0] mem [0:DEPTH-1];
    int target  = 0;   // bytes the stimulus wants read
    int started = 0;   // reads the reader has begun
    int hold    = 0;   // cycles buf_ren has been held high

    assign buf_not_empty = (target != started);
    assign buf_rdata     = (hold >= RD_LAT) ? mem[buf_raddr] : 8'hEE;

    always @(posedge clk) begin
        if (rst || !buf_ren) hold <= 0;
        else if (hold < 15)  hold <= hold + 1;
        if (!rst && en && buf_not_empty && (!busy || (out_valid && out_ready)))
            started <= started + 1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // A byte transaction is tracked by its age in cycles since the start edge:
    // ages 0..RD_LAT request the buffer, age RD_LAT+1 offers the byte.
    bit         m_active = 0;
    int         m_age    = 0;
    int         m_addr   = 0;
    logic [7:0] m_data   = 8'h00;
    int         m_cnt    = 0;

    always @(posedge clk) begin
        bit take;
        take = m_active && (m_age == RD_LAT + 1) && out_ready;
        if (rst) begin
            m_active = 0; m_age = 0; m_addr = 0; m_data = 8'h00; m_cnt = 0;
        end else begin
            if (cnt_clr)   m_cnt = 0;
            else if (take) m_cnt = (m_cnt + 1) % 65536;
            if (!m_active) begin
                if (en && buf_not_empty) begin m_active = 1; m_age = 0; end
            end else if (m_age <= RD_LAT) begin
                m_age++;
                if (m_age == RD_LAT + 1) m_data = mem[m_addr];
            end else if (out_ready) begin
                m_addr = (m_addr + 1) % DEPTH;
                if (en && buf_not_empty) m_age = 0;
                else m_active = 0;
            end
        end
    end

    // ---------------- compare + monitor ----------------
    logic [7:0] got_q[$];
    int         gt_q[$];
    int         gap_q[$];
    int         lowrun      = 0;
    int         ren_cycles  = 0;
    int         valid_cycles = 0;

    always @(negedge clk) begin
        if (check_en) begin
            chk("buf_ren",   32'(buf_ren),   32'((m_active && m_age <= RD_LAT) ? 1 : 0));
            chk("out_valid", 32'(out_valid), 32'((m_active && m_age == RD_LAT + 1) ? 1 : 0));
            chk("busy",      32'(busy),      32'(m_active ? 1 : 0));
            chk("buf_raddr", 32'(buf_raddr), 32'(m_addr));
            chk("out_data",  32'(out_data),  32'(m_data));
`ifdef SPI_RX_BUF_RD_CNT_EN
            chk("rd_count",  32'(rd_count),  32'(m_cnt));
`endif
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                gt_q.push_back(cyc);
                $display("xfer cyc=%0d addr=%0d data=%02h", cyc, buf_raddr, out_data);
            end
            if (buf_ren)   ren_cycles++;
            if (out_valid) valid_cycles++;
            if (!busy) lowrun = 0;
            else if (!buf_ren) lowrun++;
            else if (lowrun > 0) begin gap_q.push_back(lowrun); lowrun = 0; end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int n = 0;
        do begin tick(); n++; end while (!(busy == 1'b0 && target == started) && n < max_cyc);
        chk({tag, "_done"}, 32'((busy == 1'b0 && target == started) ? 1 : 0), 32'd1);
    endtask

    task automatic wait_valid(input int max_cyc, input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < max_cyc) begin tick(); n++; end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, rc, vc, bg;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i * 37 + 11);
        mem[0] = 8'hA5;
        mem[1] = 8'h01; mem[2] = 8'h02; mem[3] = 8'h03; mem[4] = 8'h04;
        mem[5] = 8'h3C;
        mem[DEPTH-1] = 8'h5A;

        rst = 1'b1; en = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (3) tick();

        // reset state
        chk("rst_ren",   32'(buf_ren),   32'd0);
        chk("rst_addr",  32'(buf_raddr), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
`ifdef SPI_RX_BUF_RD_CNT_EN
        chk("rst_cnt",   32'(rd_count),  32'd0);
`endif
        rst = 1'b0;
        check_en = 1;
        en = 1'b1;
        tick();

        // single byte
        base = got_q.size(); rc = ren_cycles; vc = valid_cycles;
        target = started + 1;
        wait_idle(50, "single");
        chk("single_cnt",   32'(got_q.size() - base), 32'd1);
        if (got_q.size() > base) chk("single_data", 32'(got_q[base]), 32'hA5);
        chk("single_ren",   32'(ren_cycles - rc),   32'd4);
        chk("single_valid", 32'(valid_cycles - vc), 32'd1);
        chk("single_addr",  32'(buf_raddr), 32'd1);

        // four back-to-back bytes
        base = got_q.size(); bg = gap_q.size();
        target = started + 4;
        wait_idle(100, "four");
        chk("four_cnt", 32'(got_q.size() - base), 32'd4);
        for (int i = 0; i < 4; i++)
            if (got_q.size() > base + i) chk("four_data", 32'(got_q[base+i]), 32'(i + 1));
        for (int i = 1; i < 4; i++)
            if (gt_q.size() > base + i) chk("four_period", 32'(gt_q[base+i] - gt_q[base+i-1]), 32'd5);
        chk("four_gaps", 32'(gap_q.size() - bg), 32'd3);
        for (int i = bg; i < gap_q.size(); i++) chk("four_gaplen", 32'(gap_q[i]), 32'd1);
        chk("four_addr", 32'(buf_raddr), 32'd5);

        // backpressure
        base = got_q.size();
        out_ready = 1'b0;
        target = started + 1;
        wait_valid(20, "bp");
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_data",  32'(out_data),  32'h3C);
            chk("bp_addr",  32'(buf_raddr), 32'd5);
            chk("bp_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_xfer_addr",  32'(buf_raddr), 32'd6);
        chk("bp_xfer_valid", 32'(out_valid), 32'd0);
        chk("bp_xfer_cnt",   32'(got_q.size() - base), 32'd1);
        wait_idle(10, "bp");

        // reset during REQ
        target = started + 1;
        tick();   // start edge
        tick();   // REQ
        rst = 1'b1;
        tick();
        chk("mrst_ren",   32'(buf_ren),   32'd0);
        chk("mrst_addr",  32'(buf_raddr), 32'd0);
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_busy",  32'(busy),      32'd0);
        rst = 1'b0;
        tick();

        // en dropped mid-byte: byte completes, then idle despite not-empty
        base = got_q.size();
        target = started + 3;
        tick();
        chk("en0_busy", 32'(busy), 32'd1);
        en = 1'b0;
        for (int i = 0; i < 20 && busy; i++) tick();
        repeat (5) tick();
        chk("en0_cnt",  32'(got_q.size() - base), 32'd1);
        if (got_q.size() > base) chk("en0_data", 32'(got_q[base]), 32'hA5);
        chk("en0_busy_after", 32'(busy), 32'd0);
        chk("en0_ne",   32'(buf_not_empty), 32'd1);
        chk("en0_addr", 32'(buf_raddr), 32'd1);
        target = started;
        en = 1'b1;
        tick();

        // drain to the top address, then wrap
        target = started + (DEPTH - 2);
        wait_idle((DEPTH - 2) * 5 + 100, "drain");
        chk("drain_addr", 32'(buf_raddr), 32'(DEPTH - 1));
        base = got_q.size();
        target = started + 1;
        wait_idle(40, "wrap");
        chk("wrap_cnt", 32'(got_q.size() - base), 32'd1);
        if (got_q.size() > base) chk("wrap_data", 32'(got_q[base]), 32'h5A);
        chk("wrap_addr", 32'(buf_raddr), 32'd0);

`ifdef SPI_RX_BUF_RD_CNT_EN
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("cnt_clr0", 32'(rd_count), 32'd0);
        target = started + 3;
        wait_idle(60, "cnt3");
        chk("cnt3", 32'(rd_count), 32'd3);
        target = started + 1;
        wait_valid(20, "cnt4");
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("cnt4_clr",   32'(rd_count),  32'd0);
        chk("cnt4_valid", 32'(out_valid), 32'd0);
        wait_idle(10, "cnt4");
`endif

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_spi_rx_buf_reader
